// File: rtl/trng_arbiter.sv
// Round-robin arbiter sharing one TRNG FIFO read port among N_REQ cores.
// Grants a burst of LEN words and returns each through valid/ready.
module trng_arbiter #(
  parameter int N_REQ      = 4,
  parameter int Dbw        = 32,
  parameter int LEN_W      = 8,
  parameter int ADDR_WIDTH = 13,
  parameter int MIN_OCCP   = 4,
  parameter int READ_LAT   = 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] req_len,
  output logic [N_REQ-1:0]       gnt,
  output logic [Dbw-1:0]         rd_data,
  output logic [N_REQ-1:0]       rd_valid,
  input  logic [N_REQ-1:0]       rd_ready,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic                   trng_ren,
  output logic                   trng_read,
  input  logic                   trng_valid,
  input  logic [ADDR_WIDTH-1:0]  trng_occp,
  input  logic [Dbw-1:0]         trng_out
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT, DELIVER, FIN
  } state_t;

  state_t           st_q, st_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lat_q, lat_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] vld_q, vld_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [Dbw-1:0]   data_q, data_d;
  logic             ren_q, ren_d;
  logic             rd_q, rd_d;
  logic             busy_q;

  logic             hit;
  logic [PW-1:0]    sel;
  logic [LEN_W-1:0] sel_len;
  logic             occ_ok;
  logic             abort;

  // Search starts just after the last winner, so it ends up lowest priority.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!hit && req[(int'(ptr_q) + k) % N_REQ]) begin
        hit = 1'b1;
        sel = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  assign sel_len = req_len[int'(sel)*LEN_W +: LEN_W];
  assign occ_ok  = trng_occp >= ADDR_WIDTH'(MIN_OCCP);
  assign abort   = !req[ptr_q];

  always_comb begin
    st_d   = st_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    lat_d  = lat_q;
    gnt_d  = gnt_q;
    vld_d  = vld_q;
    done_d = '0;
    data_d = data_q;
    ren_d  = ren_q;
    rd_d   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (hit) begin
          gnt_d = {{(N_REQ-1){1'b0}}, 1'b1} << sel;
          ren_d = 1'b1;
          cnt_d = sel_len;
          ptr_d = sel;
          st_d  = (sel_len == '0) ? FIN : ISSUE;
        end
      end
      ISSUE: begin
        if (trng_valid && occ_ok) begin
          rd_d  = 1'b1;
          lat_d = '0;
          st_d  = WAIT;
        end
      end
      WAIT: begin
        if (lat_q == 2'(READ_LAT-1)) begin
          data_d = trng_out;
          vld_d  = gnt_q;
          st_d   = DELIVER;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      DELIVER: begin
        if (rd_ready[ptr_q]) begin
          vld_d = '0;
          cnt_d = cnt_q - 1'b1;
          st_d  = (cnt_q == LEN_W'(1)) ? FIN : ISSUE;
        end
      end
      FIN: begin
        done_d = gnt_q;
        gnt_d  = '0;
        ren_d  = 1'b0;
        st_d   = IDLE;
      end
      default: st_d = IDLE;
    endcase
    // Requester gave up: drop everything, including a word in flight.
    if ((st_q == ISSUE || st_q == WAIT || st_q == DELIVER) && abort) begin
      st_d  = IDLE;
      gnt_d = '0;
      vld_d = '0;
      ren_d = 1'b0;
      rd_d  = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= IDLE;
      ptr_q  <= PW'(N_REQ-1);
      cnt_q  <= '0;
      lat_q  <= '0;
      gnt_q  <= '0;
      vld_q  <= '0;
      done_q <= '0;
      data_q <= '0;
      ren_q  <= 1'b0;
      rd_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      lat_q  <= lat_d;
      gnt_q  <= gnt_d;
      vld_q  <= vld_d;
      done_q <= done_d;
      data_q <= data_d;
      ren_q  <= ren_d;
      rd_q   <= rd_d;
      busy_q <= (st_d != IDLE);
    end
  end

  assign gnt       = gnt_q;
  assign rd_data   = data_q;
  assign rd_valid  = vld_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign trng_ren  = ren_q;
  assign trng_read = rd_q;

endmodule

// File: tb/tb_trng_arbiter.sv
// Directed bench for trng_arbiter with a first-word-fall-through TRNG model.
module tb_trng_arbiter;

  localparam int N   = 4;
  localparam int DW  = 32;
  localparam int LW  = 8;
  localparam int AW  = 13;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [N-1:0]  req;
  logic [N*LW-1:0] req_len;
  logic [N-1:0]  gnt;
  logic [DW-1:0] rd_data;
  logic [N-1:0]  rd_valid;
  logic [N-1:0]  rd_ready;
  logic [N-1:0]  done;
  logic          busy;
  logic          trng_ren;
  logic          trng_read;
  logic          trng_valid;
  logic [AW-1:0] trng_occp;
  logic [DW-1:0] trng_out;

  int tests = 0;
  int fails = 0;
  int pop_idx = 0;
  int viol = 0;
  logic prev_read = 1'b0;

  trng_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req(req), .req_len(req_len),
    .gnt(gnt), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .busy(busy),
    .trng_ren(trng_ren), .trng_read(trng_read),
    .trng_valid(trng_valid), .trng_occp(trng_occp),
    .trng_out(trng_out)
  );

  always #5 clock = ~clock;

  function automatic logic [DW-1:0] word(input int k);
    return 32'hA5A5_0000 + DW'(k);
  endfunction

  assign trng_out = word(pop_idx);

  // TRNG pop model plus bus-rule monitor
  always @(posedge clock) begin
    if (reset_n) begin
      if (trng_read) pop_idx <= pop_idx + 1;
      if (trng_read && !trng_ren) viol <= viol + 1;
      if (trng_read && prev_read) viol <= viol + 1;
      if ((rd_valid & ~gnt) != '0) viol <= viol + 1;
    end
    prev_read <= trng_read;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_len(input int i, input int l);
    req_len[i*LW +: LW] = LW'(l);
  endtask

  int base;
  int pulses;
  int stable_bad;

  initial begin
    reset_n = 1'b0;
    req = '0;
    req_len = '0;
    rd_ready = '0;
    trng_valid = 1'b1;
    trng_occp = 13'd100;
    #12;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_data", 64'(rd_data), 64'h0);
    chk("rst_valid", 64'(rd_valid), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_ren", 64'(trng_ren), 64'h0);
    chk("rst_read", 64'(trng_read), 64'h0);
    tick();
    reset_n = 1'b1;
    tick();

    // 1: single requester, three words
    base = pop_idx;
    set_len(1, 3);
    req = 4'b0010;
    rd_ready = 4'b0010;
    tick();
    chk("t1_gnt", 64'(gnt), 64'h2);
    chk("t1_ren", 64'(trng_ren), 64'h1);
    for (int w = 0; w < 3; w++) begin
      tick();
      chk("t1_read", 64'(trng_read), 64'h1);
      tick();
      chk("t1_valid", 64'(rd_valid), 64'h2);
      chk("t1_data", 64'(rd_data), 64'(word(base + w)));
      chk("t1_read_lo", 64'(trng_read), 64'h0);
      tick();
      chk("t1_valid_lo", 64'(rd_valid), 64'h0);
    end
    tick();
    req = '0;
    chk("t1_done", 64'(done), 64'h2);
    chk("t1_gnt_lo", 64'(gnt), 64'h0);
    chk("t1_busy", 64'(busy), 64'h0);
    tick();
    chk("t1_done_lo", 64'(done), 64'h0);
    chk("t1_pops", 64'(pop_idx - base), 64'd3);

    // 2: all request, round robin from reset
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) set_len(i, 1);
    req = 4'b1111;
    rd_ready = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      tick();
      chk("t2_gnt", 64'(gnt), 64'(4'b0001 << (b % 4)));
      tick();
      tick();
      tick();
      tick();
      chk("t2_done", 64'(done), 64'(4'b0001 << (b % 4)));
      chk("t2_gnt_lo", 64'(gnt), 64'h0);
    end
    req = '0;
    tick();
    chk("t2_idle", 64'(gnt), 64'h0);

    // 3: occupancy below floor stalls reads
    base = pop_idx;
    set_len(0, 2);
    trng_occp = 13'd3;
    req = 4'b0001;
    tick();
    chk("t3_gnt", 64'(gnt), 64'h1);
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (trng_read) pulses++;
    end
    chk("t3_no_read", 64'(pulses), 64'd0);
    trng_occp = 13'd8;
    for (int w = 0; w < 2; w++) begin
      tick();
      chk("t3_read", 64'(trng_read), 64'h1);
      tick();
      chk("t3_data", 64'(rd_data), 64'(word(base + w)));
      tick();
    end
    tick();
    req = '0;
    chk("t3_done", 64'(done), 64'h1);

    // 4: back-pressure holds the word
    base = pop_idx;
    set_len(1, 1);
    rd_ready = 4'b1101;
    req = 4'b0010;
    tick();
    chk("t4_gnt", 64'(gnt), 64'h2);
    tick();
    tick();
    chk("t4_valid", 64'(rd_valid), 64'h2);
    stable_bad = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (rd_valid !== 4'b0010 || rd_data !== word(base) || trng_read)
        stable_bad++;
    end
    chk("t4_stable", 64'(stable_bad), 64'd0);
    rd_ready = 4'b0010;
    tick();
    chk("t4_valid_lo", 64'(rd_valid), 64'h0);
    tick();
    req = '0;
    chk("t4_done", 64'(done), 64'h2);
    chk("t4_pops", 64'(pop_idx - base), 64'd1);

    // 5: zero-length burst
    base = pop_idx;
    set_len(2, 0);
    req = 4'b0100;
    tick();
    chk("t5_gnt", 64'(gnt), 64'h4);
    chk("t5_busy", 64'(busy), 64'h1);
    tick();
    req = '0;
    chk("t5_done", 64'(done), 64'h4);
    chk("t5_gnt_lo", 64'(gnt), 64'h0);
    tick();
    chk("t5_pops", 64'(pop_idx - base), 64'd0);

    // 6: abort in WAIT of word 2, then async reset mid-burst
    set_len(0, 4);
    rd_ready = 4'b1111;
    req = 4'b0001;
    tick();
    chk("t6_gnt", 64'(gnt), 64'h1);
    tick();
    tick();
    tick();
    tick();
    chk("t6_read2", 64'(trng_read), 64'h1);
    req = '0;
    tick();
    chk("t6_gnt_lo", 64'(gnt), 64'h0);
    chk("t6_valid_lo", 64'(rd_valid), 64'h0);
    chk("t6_done_lo", 64'(done), 64'h0);
    chk("t6_ren_lo", 64'(trng_ren), 64'h0);
    tick();
    chk("t6_done_lo2", 64'(done), 64'h0);
    set_len(3, 4);
    req = 4'b1000;
    rd_ready = '0;
    tick();
    chk("t6_gnt3", 64'(gnt), 64'h8);
    tick();
    tick();
    chk("t6_valid3", 64'(rd_valid), 64'h8);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_gnt", 64'(gnt), 64'h0);
    chk("t6_rst_valid", 64'(rd_valid), 64'h0);
    chk("t6_rst_data", 64'(rd_data), 64'h0);
    chk("t6_rst_ren", 64'(trng_ren), 64'h0);
    chk("t6_rst_busy", 64'(busy), 64'h0);
    chk("t6_rst_done", 64'(done), 64'h0);
    req = '0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("bus_rules", 64'(viol), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
